sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameters: CANVAS_WIDTH=100 (pixels/row); CANVAS_HEIGHT=100 (rows); NUM_FRAMES=100 (sprite images in ROM); SPRITE_W=16 (sprite width); SPRITE_H=16 (sprite height); FIFO_DEPTH=4 (queued requests, power of 2); PIX_W=8 (palette index width); ROM_LATENCY=2 (sprite ROM read latency, cycles).
REQ-002 SHALL have one clock, pixel_clk_in; reset is asynchronous and active-low, rst_n_in.
REQ-003 Ports (name  direction  width  meaning):
- pixel_clk_in  in  1  clock
- rst_n_in  in  1  async active-low reset
- new_frame  in  1  one-cycle frame-start strobe, shared with the upstream sprite processor
- x  in  $clog2(CANVAS_WIDTH)  sprite top-left column
- y  in  $clog2(CANVAS_HEIGHT)  sprite top-left row
- frame  in  $clog2(NUM_FRAMES)  sprite image index
- sprite_valid  in  1  x/y/frame valid this cycle; the upstream has no backpressure
- rom_addr  out  $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H)  sprite ROM address
- rom_data  in  PIX_W  ROM pixel, valid ROM_LATENCY cycles after rom_addr
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  $clog2(CANVAS_WIDTH*CANVAS_HEIGHT)  framebuffer address
- fb_data  out  PIX_W  framebuffer pixel
- busy  out  1  FSM not IDLE, or FIFO non-empty
- drop_count  out  8  saturating count of dropped requests
- overrun  out  1  sticky: new_frame arrived while busy

Function
REQ-004 On sprite_valid=1, {x,y,frame} SHALL be pushed into a FIFO_DEPTH-entry FIFO.
REQ-005 A push while the FIFO is full SHALL drop the request and increment drop_count, which saturates at 255.
REQ-006 A push and a pop in the same cycle while the FIFO is full SHALL succeed, with no drop.
REQ-007 FSM states SHALL be IDLE, LOAD, DRAW and DRAIN.
- IDLE->LOAD when the FIFO is non-empty; LOAD pops one entry into working registers (1 cycle).
- LOAD->DRAW.
- DRAW issues one rom_addr per cycle, raster order: col 0..SPRITE_W-1 within row 0..SPRITE_H-1.
- After the last address, DRAW->DRAIN; DRAIN holds for ROM_LATENCY cycles, then goes to LOAD if the FIFO is non-empty, else IDLE.
REQ-008 rom_addr SHALL equal frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col, computed at full width with no truncation.
REQ-009 Each address's (px=x+col, py=y+row) SHALL be delayed ROM_LATENCY cycles alongside it, so that it pairs with the matching rom_data.
REQ-010 fb_we SHALL assert exactly when the paired rom_data != 0 AND px < CANVAS_WIDTH AND py < CANVAS_HEIGHT; fb_addr = py*CANVAS_WIDTH + px; fb_data = rom_data.
REQ-011 The px/py sums SHALL be computed one bit wider than the operands so that off-canvas coordinates clip rather than wrap.
REQ-012 Index 0 SHALL be transparent and never written.
REQ-013 Throughput SHALL be one pixel per cycle in DRAW. Per-sprite cost is 1 + SPRITE_W*SPRITE_H + ROM_LATENCY cycles, i.e. 259 for the defaults.
REQ-014 Writes SHALL be issued in FIFO order with no overlap between sprites, so later sprites overwrite earlier ones.
REQ-015 new_frame while busy=1 SHALL set overrun; the FIFO is not flushed and the current sprite completes.
REQ-016 overrun SHALL clear only on reset.
REQ-017 frame >= NUM_FRAMES SHALL be treated as a no-op sprite: popped, no ROM reads, no writes, back to IDLE/LOAD on the next cycle.

Reset
REQ-018 While rst_n_in=0, all outputs SHALL be held at 0, the FIFO empty, the FSM in IDLE, and the delay pipeline valid bits clear.
REQ-019 Reset mid-DRAW SHALL abort the sprite immediately, with no further fb_we.
REQ-020 The first push SHALL be accepted on the first rising edge after rst_n_in deasserts.

Structure
REQ-021 The FSM state enum and a sprite-request struct {x,y,frame} SHALL live in shared package sprite_pkg, for reuse by the processor and bench.
REQ-022 The FIFO SHALL be a sub-module, sprite_req_fifo, with push/pop/full/empty and a registered output.
REQ-023 Everything else SHALL be inline in sprite_blitter.

Verification
REQ-024 The bench SHALL cover these directed scenarios (ROM model: pixel = (col+1) for row even, 0 for row odd):
- Single sprite x=10,y=20,frame=0 -> 128 writes; first fb_addr=2010, fb_data=1; last write at row 14, col 15 -> fb_addr 3425; 259 cycles IDLE-to-IDLE.
- x=95,y=90 -> only cols 0..4 and even rows 0..8 written (25 writes); no fb_addr >= 10000.
- 6 back-to-back sprite_valid pulses with the FSM busy -> 4 queued plus the first popped; drop_count=1.
- Simultaneous push/pop at full -> no drop; FIFO order preserved (check by frame index).
- new_frame during DRAW -> overrun=1 and stays 1; the sprite finishes all its writes.
- rst_n_in low at pixel 50 of DRAW -> fb_we=0 immediately, busy=0; the next sprite after release draws correctly.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite blitter, its upstream sprite processor and the bench.
package sprite_pkg;

  // Default geometry; sprite_req_t is sized from these.
  localparam int unsigned DefCanvasWidth  = 100;
  localparam int unsigned DefCanvasHeight = 100;
  localparam int unsigned DefNumFrames    = 100;

  localparam int unsigned ReqXW = $clog2(DefCanvasWidth);
  localparam int unsigned ReqYW = $clog2(DefCanvasHeight);
  localparam int unsigned ReqFW = $clog2(DefNumFrames);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDraw  = 2'd2,
    StDrain = 2'd3
  } blit_state_e;

  typedef struct packed {
    logic [ReqXW-1:0] x;
    logic [ReqYW-1:0] y;
    logic [ReqFW-1:0] frame;
  } sprite_req_t;

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sprite_req_fifo.sv
// Request FIFO for the sprite blitter. The head entry is read straight from the storage
// flops (no write-to-read bypass), so a push is visible at the output one cycle later.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it
// is dropped and drop_o pulses.
module sprite_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign drop_o     = push_i && !do_push;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance and storage write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: queues {x,y,frame} requests, walks each sprite in raster order issuing one
// ROM address per cycle, and writes non-transparent, on-canvas pixels to the framebuffer.
// Screen coordinates travel alongside each ROM read so they meet the returning pixel.
// ROM_LATENCY must be at least 1.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned CANVAS_WIDTH  = 100,
  parameter int unsigned CANVAS_HEIGHT = 100,
  parameter int unsigned NUM_FRAMES    = 100,
  parameter int unsigned SPRITE_W      = 16,
  parameter int unsigned SPRITE_H      = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PIX_W         = 8,
  parameter int unsigned ROM_LATENCY   = 2,
  localparam int unsigned XW  = $clog2(CANVAS_WIDTH),
  localparam int unsigned YW  = $clog2(CANVAS_HEIGHT),
  localparam int unsigned FW  = $clog2(NUM_FRAMES),
  localparam int unsigned RAW = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H),
  localparam int unsigned FAW = $clog2(CANVAS_WIDTH * CANVAS_HEIGHT)
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic             new_frame,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [FW-1:0]    frame,
  input  logic             sprite_valid,
  output logic [RAW-1:0]   rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [FAW-1:0]   fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             busy,
  output logic [7:0]       drop_count,
  output logic             overrun
);

  localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int unsigned DW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int unsigned QW = XW + YW + FW;

  // Bounds widened to match the one-bit-wider coordinate sums.
  localparam logic [XW:0] CanvasW   = (XW+1)'(CANVAS_WIDTH);
  localparam logic [YW:0] CanvasH   = (YW+1)'(CANVAS_HEIGHT);
  localparam logic [FW:0] NumFrames = (FW+1)'(NUM_FRAMES);

  // Request queue.
  logic [QW-1:0] fifo_head;
  logic          fifo_full, fifo_empty, fifo_drop, fifo_pop;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [FW-1:0] head_f;

  sprite_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (QW)
  ) u_fifo (
    .clk_i       (pixel_clk_in),
    .rst_ni      (rst_n_in),
    .push_i      (sprite_valid),
    .push_data_i ({x, y, frame}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign head_x = fifo_head[QW-1 -: XW];
  assign head_y = fifo_head[FW +: YW];
  assign head_f = fifo_head[FW-1:0];

  // FSM and working registers.
  blit_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] drain_q, drain_d;

  // Status registers.
  logic [7:0] drop_count_q, drop_count_d;
  logic       overrun_q, overrun_d;

  // Coordinate delay line matching the ROM read latency.
  logic          pipe_vld_q [ROM_LATENCY];
  logic          pipe_vld_d [ROM_LATENCY];
  logic [XW:0]   pipe_px_q  [ROM_LATENCY];
  logic [XW:0]   pipe_px_d  [ROM_LATENCY];
  logic [YW:0]   pipe_py_q  [ROM_LATENCY];
  logic [YW:0]   pipe_py_d  [ROM_LATENCY];

  logic [RAW-1:0] addr_calc;
  logic [XW:0]    px_new;
  logic [YW:0]    py_new;
  logic           tap_vld;
  logic [XW:0]    tap_px;
  logic [YW:0]    tap_py;
  logic           on_canvas;

  // Sequencing: pop into working regs, raster walk, then wait out the ROM latency.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    frame_d  = frame_q;
    col_d    = col_q;
    row_d    = row_q;
    drain_d  = drain_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        fifo_pop = 1'b1;
        x_d      = head_x;
        y_d      = head_y;
        frame_d  = head_f;
        col_d    = '0;
        row_d    = '0;
        drain_d  = '0;
        // Out-of-range frame index: consume the request, draw nothing.
        state_d  = ({1'b0, head_f} < NumFrames) ? StDraw : StIdle;
      end
      StDraw: begin
        if (col_q == CW'(SPRITE_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(SPRITE_H - 1)) begin
            state_d = StDrain;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DW'(ROM_LATENCY - 1)) begin
          state_d = fifo_empty ? StIdle : StLoad;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drop counter and sticky overrun flag.
  always_comb begin
    drop_count_d = fifo_drop ? sat_inc8(drop_count_q) : drop_count_q;
    overrun_d    = overrun_q | (new_frame & busy);
  end

  // ROM address and screen coordinates for the pixel being fetched this cycle.
  assign addr_calc = RAW'(frame_q) * RAW'(SPRITE_W * SPRITE_H)
                   + RAW'(row_q) * RAW'(SPRITE_W) + RAW'(col_q);
  assign px_new    = (XW+1)'(x_q) + (XW+1)'(col_q);
  assign py_new    = (YW+1)'(y_q) + (YW+1)'(row_q);

  // Delay line next-state: stage 0 takes the current fetch, others shift.
  always_comb begin
    pipe_vld_d[0] = (state_q == StDraw);
    pipe_px_d[0]  = px_new;
    pipe_py_d[0]  = py_new;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_px_d[i]  = pipe_px_q[i-1];
      pipe_py_d[i]  = pipe_py_q[i-1];
    end
  end

  // State, working and delay-line registers.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      frame_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      drain_q      <= '0;
      drop_count_q <= '0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_px_q[i]  <= '0;
        pipe_py_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
      col_q        <= col_d;
      row_q        <= row_d;
      drain_q      <= drain_d;
      drop_count_q <= drop_count_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_px_q[i]  <= pipe_px_d[i];
        pipe_py_q[i]  <= pipe_py_d[i];
      end
    end
  end

  // Framebuffer side: pair the delayed coordinates with the returning ROM pixel.
  assign tap_vld   = pipe_vld_q[ROM_LATENCY-1];
  assign tap_px    = pipe_px_q[ROM_LATENCY-1];
  assign tap_py    = pipe_py_q[ROM_LATENCY-1];
  assign on_canvas = (tap_px < CanvasW) && (tap_py < CanvasH);

  // Index 0 is transparent; address and data are zeroed when not writing.
  assign fb_we    = tap_vld && (rom_data != '0) && on_canvas;
  assign fb_addr  = fb_we ? (FAW'(tap_py) * FAW'(CANVAS_WIDTH) + FAW'(tap_px)) : '0;
  assign fb_data  = fb_we ? rom_data : '0;
  assign rom_addr = (state_q == StDraw) ? addr_calc : '0;

  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign drop_count = drop_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: expected framebuffer writes and sprite frame order are
// queued when each request is issued; monitors pop and compare as the DUT produces them.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int LAT = 2;
  localparam int SPR = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_frame = 1'b0;
  logic        sprite_valid = 1'b0;
  logic [6:0]  x = '0;
  logic [6:0]  y = '0;
  logic [6:0]  frame = '0;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        fb_we;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        busy;
  logic [7:0]  drop_count;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int exp_addr[$];
  int exp_data[$];
  int exp_frame[$];
  int wr_cnt = 0;
  int first_addr = -1;
  int last_addr = -1;
  int max_addr = 0;
  int st_cyc = 0;

  logic [14:0] rom_pipe [LAT];

  sprite_blitter #(
    .ROM_LATENCY (LAT)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .new_frame    (new_frame),
    .x            (x),
    .y            (y),
    .frame        (frame),
    .sprite_valid (sprite_valid),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .busy         (busy),
    .drop_count   (drop_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ROM model: col+1 on even rows, transparent on odd rows, LAT cycles of latency.
  function automatic logic [7:0] rom_model(input logic [14:0] a);
    int loc;
    int row;
    int col;
    loc = int'(a) % SPR;
    row = loc / 16;
    col = loc % 16;
    return (row % 2 == 0) ? 8'(col + 1) : 8'd0;
  endfunction

  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end

  assign rom_data = rom_model(rom_pipe[LAT-1]);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model of one sprite's writes, straight from the ROM pattern and clipping rules.
  task automatic expect_sprite(input sprite_req_t r);
    int d;
    int px;
    int py;
    if (int'(r.frame) >= 100) return;
    exp_frame.push_back(int'(r.frame));
    for (int row = 0; row < 16; row++) begin
      for (int col = 0; col < 16; col++) begin
        d  = (row % 2 == 0) ? col + 1 : 0;
        px = int'(r.x) + col;
        py = int'(r.y) + row;
        if (d != 0 && px < 100 && py < 100) begin
          exp_addr.push_back(py * 100 + px);
          exp_data.push_back(d);
        end
      end
    end
  endtask

  task automatic set_req(input sprite_req_t r);
    x = r.x;
    y = r.y;
    frame = r.frame;
    sprite_valid = 1'b1;
  endtask

  task automatic push_one(input sprite_req_t r);
    @(negedge clk);
    set_req(r);
    @(negedge clk);
    sprite_valid = 1'b0;
  endtask

  task automatic clear_stats();
    wr_cnt = 0;
    st_cyc = 0;
    first_addr = -1;
    last_addr = -1;
    max_addr = 0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic wait_state(input blit_state_e s, input int limit, input string name);
    int n;
    n = 0;
    while (dut.state_q != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(dut.state_q), int'(s));
  endtask

  // Monitor: framebuffer writes, sprite start frame order, non-idle cycle count.
  always @(negedge clk) begin
    if (fb_we) begin
      wr_cnt++;
      if (first_addr < 0) first_addr = int'(fb_addr);
      last_addr = int'(fb_addr);
      if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      if (exp_addr.size() == 0) begin
        check("unexpected_write", int'(fb_addr), -1);
      end else begin
        check("wr_addr", int'(fb_addr), exp_addr.pop_front());
        check("wr_data", int'(fb_data), exp_data.pop_front());
      end
    end
    if (dut.state_q == StDraw && (int'(rom_addr) % SPR) == 0) begin
      if (exp_frame.size() == 0) check("unexpected_sprite", int'(rom_addr) / SPR, -1);
      else check("frame_order", int'(rom_addr) / SPR, exp_frame.pop_front());
    end
    if (dut.state_q != StIdle) st_cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sprite_req_t r;
    int n;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // new_frame while idle leaves overrun clear.
    @(negedge clk);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    check("idle_newframe_overrun", int'(overrun), 0);

    // Single sprite.
    clear_stats();
    r = '{x: 7'd10, y: 7'd20, frame: 7'd0};
    expect_sprite(r);
    push_one(r);
    wait_idle(1000, "single_idle");
    check("single_writes", wr_cnt, 128);
    check("single_first_addr", first_addr, 2010);
    check("single_last_addr", last_addr, 3425);
    check("single_cycles", st_cyc, 259);

    // Clipping at the bottom-right corner.
    clear_stats();
    r = '{x: 7'd95, y: 7'd90, frame: 7'd1};
    expect_sprite(r);
    push_one(r);
    wait_idle(1000, "clip_idle");
    check("clip_writes", wr_cnt, 25);
    check("clip_max_below_10000", int'(max_addr < 10000), 1);
    check("clip_max_addr", max_addr, 9899);

    // Burst of 6: one popped, four queued, the last dropped.
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      r = '{x: 7'(i * 15), y: 7'd50, frame: 7'(2 + i)};
      if (i < 5) expect_sprite(r);
      @(negedge clk);
      set_req(r);
    end
    @(negedge clk);
    sprite_valid = 1'b0;
    check("burst_drop", int'(drop_count), 1);

    // Push on the LOAD cycle with the queue full: accepted, no drop.
    wait_state(StLoad, 600, "reach_load");
    r = '{x: 7'd80, y: 7'd70, frame: 7'd8};
    expect_sprite(r);
    set_req(r);
    @(negedge clk);
    sprite_valid = 1'b0;
    check("full_pushpop_drop", int'(drop_count), 1);
    wait_idle(3000, "burst_idle");
    check("burst_writes", wr_cnt, 768);
    check("burst_frames_left", exp_frame.size(), 0);

    // new_frame during DRAW.
    clear_stats();
    r = '{x: 7'd20, y: 7'd30, frame: 7'd9};
    expect_sprite(r);
    push_one(r);
    wait_state(StDraw, 20, "reach_draw");
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    check("overrun_set", int'(overrun), 1);
    wait_idle(1000, "overrun_idle");
    check("overrun_sticky", int'(overrun), 1);
    check("overrun_writes", wr_cnt, 128);

    // Out-of-range frame followed by a real sprite.
    clear_stats();
    r = '{x: 7'd0, y: 7'd0, frame: 7'd120};
    expect_sprite(r);
    @(negedge clk);
    set_req(r);
    r = '{x: 7'd0, y: 7'd0, frame: 7'd10};
    expect_sprite(r);
    @(negedge clk);
    set_req(r);
    @(negedge clk);
    sprite_valid = 1'b0;
    wait_idle(1000, "noop_idle");
    check("noop_writes", wr_cnt, 128);
    check("noop_cycles", st_cyc, 260);

    // Reset at pixel 50 of DRAW.
    clear_stats();
    r = '{x: 7'd40, y: 7'd40, frame: 7'd11};
    expect_sprite(r);
    push_one(r);
    n = 0;
    while (!(dut.state_q == StDraw && int'(rom_addr) == 11 * SPR + 50) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pixel50_addr", int'(rom_addr), 11 * SPR + 50);
    check("writes_before_reset", wr_cnt, 32);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_fb_we", int'(fb_we), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_drop", int'(drop_count), 0);
    exp_addr.delete();
    exp_data.delete();
    exp_frame.delete();
    @(negedge clk);
    check("midrst_fb_we_held", int'(fb_we), 0);

    // Release and push on the very first edge.
    @(negedge clk);
    clear_stats();
    rst_n = 1'b1;
    r = '{x: 7'd50, y: 7'd60, frame: 7'd12};
    expect_sprite(r);
    set_req(r);
    @(negedge clk);
    sprite_valid = 1'b0;
    check("post_rst_accept", int'(busy), 1);
    wait_idle(1000, "post_rst_idle");
    check("post_rst_writes", wr_cnt, 128);
    check("post_rst_cycles", st_cyc, 259);
    check("queue_empty", exp_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
